// File: rtl/param_regfile.sv
// param_regfile: two-read, one-write register file with a busy scoreboard and a walking clear.
// Define REGFILE_BYPASS_EN to forward an accepted write to a matching read port in the same cycle.
module param_regfile #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [1:0] IDLE = 2'd0, CLEAR = 2'd1, DONE = 2'd2;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [1:0] state;
    logic [ADDR_W-1:0] ptr;
    logic wrAcc, byp1, byp2;

    function automatic logic isZero(input logic [ADDR_W-1:0] a);
        return ZERO_REG != 0 && a == '0;
    endfunction

    assign clr_busy = state == CLEAR;
    assign clr_done = state == DONE;
    assign wr_ready = !clr_busy;
    assign wrAcc = wr_en && wr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr <= '0;
            busy <= '0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            state <= (state == IDLE && clr_req) ? CLEAR :
                     (state == CLEAR && ptr == '1) ? DONE :
                     (state == DONE) ? IDLE : state;
            ptr <= clr_busy ? ptr + ADDR_W'(1) : '0;
            if (clr_busy) begin
                regs[ptr] <= '0;
                busy[ptr] <= 1'b0;
            end
            if (wrAcc && !isZero(wr_addr)) regs[wr_addr] <= wr_data;
            if (wrAcc) busy[wr_addr] <= 1'b0;
            // placed after the write clear so a same-cycle mark wins
            if (sb_set && !clr_busy && !isZero(sb_addr)) busy[sb_addr] <= 1'b1;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign byp1 = wrAcc && wr_addr == rd_addr1;
    assign byp2 = wrAcc && wr_addr == rd_addr2;
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign rd_data1 = isZero(rd_addr1) ? '0 : byp1 ? wr_data : regs[rd_addr1];
    assign rd_data2 = isZero(rd_addr2) ? '0 : byp2 ? wr_data : regs[rd_addr2];
    assign rd_busy1 = !isZero(rd_addr1) && busy[rd_addr1];
    assign rd_busy2 = !isZero(rd_addr2) && busy[rd_addr2];
endmodule

// File: tb/tb_param_regfile.sv
// tb_param_regfile: directed bench for param_regfile, default and 32x32 instances.
module tb_param_regfile;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [3:0] rdAddr1 = '0, rdAddr2 = '0, wrAddr = '0, sbAddr = '0;
    logic [15:0] rdData1, rdData2, wrData = '0;
    logic rdBusy1, rdBusy2, wrReady, clrBusy, clrDone;
    logic wrEn = 1'b0, sbSet = 1'b0, clrReq = 1'b0;

    logic [4:0] bRdAddr1 = '0, bRdAddr2 = '0, bWrAddr = '0, bSbAddr = '0;
    logic [31:0] bRdData1, bRdData2, bWrData = '0;
    logic bRdBusy1, bRdBusy2, bWrReady, bClrBusy, bClrDone;
    logic bWrEn = 1'b0, bSbSet = 1'b0, bClrReq = 1'b0;

    param_regfile dutA (
        .clk(clk), .rst_n(rst_n),
        .rd_addr1(rdAddr1), .rd_addr2(rdAddr2), .rd_data1(rdData1), .rd_data2(rdData2),
        .rd_busy1(rdBusy1), .rd_busy2(rdBusy2),
        .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .wr_ready(wrReady),
        .sb_set(sbSet), .sb_addr(sbAddr),
        .clr_req(clrReq), .clr_busy(clrBusy), .clr_done(clrDone)
    );

    param_regfile #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dutB (
        .clk(clk), .rst_n(rst_n),
        .rd_addr1(bRdAddr1), .rd_addr2(bRdAddr2), .rd_data1(bRdData1), .rd_data2(bRdData2),
        .rd_busy1(bRdBusy1), .rd_busy2(bRdBusy2),
        .wr_en(bWrEn), .wr_addr(bWrAddr), .wr_data(bWrData), .wr_ready(bWrReady),
        .sb_set(bSbSet), .sb_addr(bSbAddr),
        .clr_req(bClrReq), .clr_busy(bClrBusy), .clr_done(bClrDone)
    );

    int tests = 0, fails = 0;
    string tagQ[$];
    logic [63:0] valQ[$];

    task automatic push(input string t, input logic [63:0] v);
        tagQ.push_back(t);
        valQ.push_back(v);
    endtask

    task automatic check(input logic [63:0] obs);
        string t;
        logic [63:0] e;
        tests++;
        if (valQ.size() == 0) begin
            fails++;
            $error("FAIL sb_empty: observed %0h with no expected value", obs);
        end else begin
            t = tagQ.pop_front();
            e = valQ.pop_front();
            assert (obs === e) else begin
                fails++;
                $error("FAIL %s: observed %0h expected %0h", t, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int n;
    logic sawDone;

    initial begin
        rst_n = 1'b0;
        tick();
        push("rst_clr_busy", 0); check(clrBusy);
        push("rst_clr_done", 0); check(clrDone);
        push("rst_wr_ready", 1); check(wrReady);
        rdAddr1 = 5; #1;
        push("rst_r5", 0); check(rdData1);
        tick(); rst_n = 1'b1; tick();

        wrEn = 1; wrAddr = 5; wrData = 16'h1234; #1;
`ifdef REGFILE_BYPASS_EN
        push("r5_same_cycle", 16'h1234);
`else
        push("r5_same_cycle", 0);
`endif
        check(rdData1);
        tick(); wrEn = 0; #1;
        push("r5_next", 16'h1234); check(rdData1);

        wrEn = 1; wrAddr = 0; wrData = 16'hFFFF; rdAddr1 = 0; rdAddr2 = 0; #1;
        push("r0_port1_same", 0); check(rdData1);
        push("r0_port2_same", 0); check(rdData2);
        tick(); wrEn = 0; sbSet = 1; sbAddr = 0; #1;
        push("r0_port1_after", 0); check(rdData1);
        push("r0_port2_after", 0); check(rdData2);
        tick(); sbSet = 0; #1;
        push("r0_busy1", 0); check(rdBusy1);
        push("r0_busy2", 0); check(rdBusy2);

        sbSet = 1; sbAddr = 3; rdAddr1 = 3; #1;
        push("r3_busy_pre", 0); check(rdBusy1);
        tick(); sbSet = 0; #1;
        push("r3_busy_set", 1); check(rdBusy1);
        sbSet = 1; wrEn = 1; wrAddr = 3; wrData = 16'hAAAA;
        tick(); sbSet = 0; wrEn = 0; #1;
        push("r3_busy_collide", 1); check(rdBusy1);
        push("r3_data", 16'hAAAA); check(rdData1);
        wrEn = 1; tick(); wrEn = 0; #1;
        push("r3_busy_clear", 0); check(rdBusy1);

        for (int i = 0; i < 16; i++) begin
            wrEn = 1; wrAddr = 4'(i); wrData = 16'(i * 16'h0101 + 1);
            tick();
        end
        wrEn = 0; sbSet = 1; sbAddr = 7;
        tick(); sbSet = 0;
        rdAddr1 = 15; rdAddr2 = 7; #1;
        push("fill_r15", 16'h0F10); check(rdData1);
        push("fill_r7_busy", 1); check(rdBusy2);

        clrReq = 1; tick(); clrReq = 0; #1;
        push("clear_wr_ready", 0); check(wrReady);
        n = 0;
        while (clrBusy && n < 40) begin
            wrEn = (n == 14); wrAddr = 2; wrData = 16'hBEEF;
            sbSet = (n == 15); sbAddr = 1;
            n++;
            tick();
        end
        wrEn = 0; sbSet = 0; #1;
        push("walk_len16", 16); check(64'(n));
        push("done_pulse", 1); check(clrDone);
        tick(); #1;
        push("done_low", 0); check(clrDone);
        push("idle_clr_busy", 0); check(clrBusy);
        push("idle_wr_ready", 1); check(wrReady);
        for (int i = 0; i < 16; i++) begin
            rdAddr1 = 4'(i); #1;
            push($sformatf("cleared_r%0d", i), 0); check(rdData1);
        end
        rdAddr2 = 7; #1;
        push("cleared_busy7", 0); check(rdBusy2);
        rdAddr2 = 1; #1;
        push("sb_ignored_busy1", 0); check(rdBusy2);

        wrEn = 1; wrAddr = 12; wrData = 16'h5A5A;
        tick(); wrEn = 0; rdAddr1 = 12; clrReq = 1;
        tick(); clrReq = 0;
        repeat (7) tick();
        #1;
        push("midwalk_busy", 1); check(clrBusy);
        push("midwalk_r12", 16'h5A5A); check(rdData1);
        rst_n = 1'b0; #1;
        push("abort_clr_busy", 0); check(clrBusy);
        push("abort_r12", 0); check(rdData1);
        push("abort_wr_ready", 1); check(wrReady);
        tick(); rst_n = 1'b1;
        sawDone = 1'b0;
        repeat (20) begin
            tick();
            if (clrDone) sawDone = 1'b1;
        end
        push("abort_no_done", 0); check(sawDone);

        bWrEn = 1; bWrAddr = 31; bWrData = 32'hDEADBEEF; bRdAddr1 = 31;
        tick(); bWrEn = 0; #1;
        push("b_r31", 32'hDEADBEEF); check(bRdData1);
        bClrReq = 1; tick(); bClrReq = 0;
        n = 0;
        while (bClrBusy && n < 80) begin
            n++;
            tick();
        end
        #1;
        push("b_walk_len32", 32); check(64'(n));
        push("b_done_pulse", 1); check(bClrDone);
        tick(); #1;
        push("b_r31_cleared", 0); check(bRdData1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
